// File: rtl/ncpu32k_bpu_ctrl.sv
// Branch predictor update sequencer: clears the table after reset/flush, then
// funnels two resolution writeback streams through a small queue into bpu_wb.
module ncpu32k_bpu_ctrl #(
    parameter int CONFIG_BPU_IDX_DW    = 6,
    parameter int CONFIG_BPU_WBQ_DEPTH = 4,
    parameter int NCPU_AW              = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [NCPU_AW-3:0] req0_pc,
    input  logic               req0_taken,
    input  logic [NCPU_AW-3:0] req0_tgt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [NCPU_AW-3:0] req1_pc,
    input  logic               req1_taken,
    input  logic [NCPU_AW-3:0] req1_tgt,
    output logic               bpu_wb,
    output logic [NCPU_AW-3:0] bpu_wb_insn_pc,
    output logic               bpu_wb_taken,
    output logic [NCPU_AW-3:0] bpu_wb_tgt,
    output logic               bpu_wb_clr,
    input  logic               bpu_pred_taken_i,
    output logic               bpu_pred_taken,
    output logic               busy
);

    localparam int IDX = CONFIG_BPU_IDX_DW;
    localparam int DEPTH = CONFIG_BPU_WBQ_DEPTH;
    localparam logic [IDX-1:0] IDX_LAST = '1;
    localparam logic [IDX-1:0] IDX_ONE = {{(IDX-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX-1:0]     idx;
    logic [1:0]         rptr;
    logic [1:0]         wptr;
    logic [1:0]         wptr_req1;
    logic [2:0]         count;
    logic [2:0]         count_nxt;
    logic               push0;
    logic               push1;
    logic               pop;
    logic [NCPU_AW-3:0] q_pc    [DEPTH];
    logic [NCPU_AW-3:0] q_tgt   [DEPTH];
    logic               q_taken [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A flush holds or returns the walk to INIT; the last clear write hands over to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = INIT;
            INIT:    if (!flush && idx == IDX_LAST) state_nxt = RUN;
            RUN:     if (flush) state_nxt = INIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        bpu_wb         = 1'b0;
        bpu_wb_clr     = 1'b0;
        bpu_wb_insn_pc = '0;
        bpu_wb_taken   = 1'b0;
        bpu_wb_tgt     = '0;
        // Readies use the registered count, so a same-cycle pop never frees a slot early.
        if (state != IDLE && !flush) begin
            req0_ready = (count <= 3'(DEPTH - 1));
            req1_ready = (count <= 3'(DEPTH - 2));
        end
        case (state)
            INIT: begin
                bpu_wb         = 1'b1;
                bpu_wb_clr     = 1'b1;
                bpu_wb_insn_pc = {{(NCPU_AW - 2 - IDX){1'b0}}, idx};
            end
            RUN: begin
                bpu_wb         = (count != 3'd0) && !flush;
                bpu_wb_insn_pc = q_pc[rptr];
                bpu_wb_taken   = q_taken[rptr];
                bpu_wb_tgt     = q_tgt[rptr];
            end
            default: ;
        endcase
    end

    assign busy           = (state != RUN);
    assign bpu_pred_taken = bpu_pred_taken_i && (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         idx <= '0;
        else if (state == IDLE || flush)    idx <= '0;
        else if (state == INIT)             idx <= idx + IDX_ONE;
    end

    assign push0     = req0_valid && req0_ready;
    assign push1     = req1_valid && req1_ready;
    assign pop       = bpu_wb && (state == RUN);
    assign wptr_req1 = wptr + {1'b0, push0};
    assign count_nxt = count + {2'b00, push0} + {2'b00, push1} - {2'b00, pop};

    // req0 is the older instruction, so it always takes the first free slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_tgt[i]   <= '0;
                q_taken[i] <= 1'b0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push0) begin
                q_pc[wptr]    <= req0_pc;
                q_tgt[wptr]   <= req0_tgt;
                q_taken[wptr] <= req0_taken;
            end
            if (push1) begin
                q_pc[wptr_req1]    <= req1_pc;
                q_tgt[wptr_req1]   <= req1_tgt;
                q_taken[wptr_req1] <= req1_taken;
            end
            wptr  <= wptr + {1'b0, push0} + {1'b0, push1};
            rptr  <= rptr + {1'b0, pop};
            count <= count_nxt;
        end
    end

endmodule
